// File: rtl/reg_status_file_if.sv
// ---------------------------------------------------------------------------
// reg_status_file_if
//   Bundles the dispatch-read, ROB launch/commit and broadcast signals of the
//   register status file. The slave modport is the register file itself; the
//   master modport is the core side (dispatch stage + ROB).
//
//   Core -> file : rdy_in, clear_in, launch_*, commit_*, rd_addr
//   File -> core : rd_busy, rd_tag, rd_value, bcast_*, busy_cnt
// ---------------------------------------------------------------------------
interface reg_status_file_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 5,
    parameter int NREAD = 2
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic                   rdy_in;
    logic                   clear_in;
    logic                   launch_valid;
    logic [RW-1:0]          launch_reg;
    logic [TAG_W-1:0]       launch_tag;
    logic                   commit_valid;
    logic [RW-1:0]          commit_reg;
    logic [TAG_W-1:0]       commit_tag;
    logic [XLEN-1:0]        commit_value;
    logic [NREAD*RW-1:0]    rd_addr;
    logic [NREAD-1:0]       rd_busy;
    logic [NREAD*TAG_W-1:0] rd_tag;
    logic [NREAD*XLEN-1:0]  rd_value;
    logic                   bcast_valid;
    logic [TAG_W-1:0]       bcast_tag;
    logic [XLEN-1:0]        bcast_value;
    logic [CW-1:0]          busy_cnt;

    modport master (
        output rdy_in, clear_in,
        output launch_valid, launch_reg, launch_tag,
        output commit_valid, commit_reg, commit_tag, commit_value,
        output rd_addr,
        input  rd_busy, rd_tag, rd_value,
        input  bcast_valid, bcast_tag, bcast_value, busy_cnt
    );

    modport slave (
        input  rdy_in, clear_in,
        input  launch_valid, launch_reg, launch_tag,
        input  commit_valid, commit_reg, commit_tag, commit_value,
        input  rd_addr,
        output rd_busy, rd_tag, rd_value,
        output bcast_valid, bcast_tag, bcast_value, busy_cnt
    );
endinterface

// File: rtl/reg_status_file.sv
// ---------------------------------------------------------------------------
// reg_status_file
//   Architectural register file with per-register rename status (busy bit +
//   ROB tag). Dispatch reads NREAD operands combinationally; ROB launch marks a
//   destination busy; ROB commit writes the value, releases the rename if it
//   is still the newest one, and broadcasts the result one cycle later.
//   Register 0 is hardwired to zero and never busy.
//
//   Ports:
//     clk_in  - clock
//     rst_in  - asynchronous active-high reset
//     bus     - reg_status_file_if.slave (launch/commit/read/broadcast)
// ---------------------------------------------------------------------------
module reg_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 5,
    parameter int NREAD = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    reg_status_file_if.slave    bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [XLEN-1:0]  r_value [NREG];
    logic [TAG_W-1:0] r_tag   [NREG];
    logic [NREG-1:0]  r_busy;
    logic             r_bcast_valid;
    logic [TAG_W-1:0] r_bcast_tag;
    logic [XLEN-1:0]  r_bcast_value;
    logic [CW-1:0]    r_busy_cnt;

    logic             w_launch_en;
    logic             w_launch_new;
    logic             w_commit_en;
    logic             w_release;
    logic [NREG-1:0]  w_busy_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [RW-1:0]    w_rd_addr [NREAD];

    // Launch is dropped while flushing; r0 never takes a rename.
    assign w_launch_en  = bus.launch_valid && (bus.launch_reg != '0) && !bus.clear_in;
    assign w_launch_new = w_launch_en && !r_busy[bus.launch_reg];
    assign w_commit_en  = bus.commit_valid && (bus.commit_reg != '0);

    // Release only when the committing entry is still the newest rename and
    // no younger launch to the same register arrives in this very cycle.
    assign w_release = w_commit_en
                     && r_busy[bus.commit_reg]
                     && (r_tag[bus.commit_reg] == bus.commit_tag)
                     && !(bus.launch_valid && (bus.launch_reg == bus.commit_reg));

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_busy_cnt;
        if (bus.clear_in) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_release)   w_busy_nxt[bus.commit_reg] = 1'b0;
            if (w_launch_en) w_busy_nxt[bus.launch_reg] = 1'b1;
            w_cnt_nxt = r_busy_cnt + CW'(w_launch_new) - CW'(w_release);
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the value/tag arrays are reset because reset must leave every register reading zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy        <= '0;
            r_bcast_valid <= 1'b0;
            r_bcast_tag   <= '0;
            r_bcast_value <= '0;
            r_busy_cnt    <= '0;
        end else if (bus.rdy_in) begin
            if (w_commit_en) r_value[bus.commit_reg] <= bus.commit_value;
            if (w_launch_en) r_tag[bus.launch_reg]   <= bus.launch_tag;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
            // Broadcast fires for every commit, including r0.
            r_bcast_valid <= bus.commit_valid;
            if (bus.commit_valid) begin
                r_bcast_tag   <= bus.commit_tag;
                r_bcast_value <= bus.commit_value;
            end
        end
    end

    // Read ports: stored state plus same-cycle commit bypass and flush override.
    always_comb begin
        bus.rd_busy  = '0;
        bus.rd_tag   = '0;
        bus.rd_value = '0;
        for (int k = 0; k < NREAD; k++) begin
            w_rd_addr[k] = bus.rd_addr[k*RW +: RW];
            if (w_rd_addr[k] != '0) begin
                bus.rd_busy[k]              = r_busy[w_rd_addr[k]];
                bus.rd_tag[k*TAG_W +: TAG_W] = r_tag[w_rd_addr[k]];
                bus.rd_value[k*XLEN +: XLEN] = r_value[w_rd_addr[k]];
                if (bus.rdy_in && bus.commit_valid && (w_rd_addr[k] == bus.commit_reg)
                    && r_busy[w_rd_addr[k]] && (r_tag[w_rd_addr[k]] == bus.commit_tag)) begin
                    bus.rd_busy[k]              = 1'b0;
                    bus.rd_value[k*XLEN +: XLEN] = bus.commit_value;
                end
                if (bus.rdy_in && bus.clear_in) bus.rd_busy[k] = 1'b0;
            end
        end
    end

    assign bus.bcast_valid = r_bcast_valid;
    assign bus.bcast_tag   = r_bcast_tag;
    assign bus.bcast_value = r_bcast_value;
    assign bus.busy_cnt    = r_busy_cnt;

endmodule

// File: tb/tb_reg_status_file.sv
// ---------------------------------------------------------------------------
// tb_reg_status_file
//   Drives directed and random launch/commit/read traffic. A behavioural
//   model (plain arrays) predicts read ports and busy count; the expected
//   broadcast of each clock edge is queued and checked by a separate monitor.
// ---------------------------------------------------------------------------
module tb_reg_status_file;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 5;
    localparam int NREAD = 2;

    typedef struct {
        bit              v;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } bcast_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    reg_status_file_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NREAD(NREAD)) bus ();

    reg_status_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NREAD(NREAD)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [XLEN-1:0]  m_val  [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];
    bit               m_busy [NREG];
    bcast_t           m_prev;
    bcast_t           exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_val[i]  = '0;
            m_tag[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_prev = '{v: 1'b0, tag: '0, val: '0};
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 1; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Monitor: one queued broadcast expectation per clock edge that the bench issued.
    always @(negedge clk_in) begin
        bcast_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bcast_valid", 64'(bus.bcast_valid), 64'(e.v));
            if (e.v) begin
                check("bcast_tag",   64'(bus.bcast_tag),   64'(e.tag));
                check("bcast_value", 64'(bus.bcast_value), 64'(e.val));
            end
        end
    end

    // One clock: drive at negedge, check reads before the edge, update model at the edge.
    task automatic cycle(input bit rdy, input bit clr,
                         input bit lv, input logic [4:0] lr, input logic [TAG_W-1:0] lt,
                         input bit cv, input logic [4:0] cr, input logic [TAG_W-1:0] ct,
                         input logic [XLEN-1:0] cval,
                         input logic [4:0] a0, input logic [4:0] a1);
        logic [4:0] addr [NREAD];
        bit rel;
        @(negedge clk_in);
        bus.rdy_in = rdy; bus.clear_in = clr;
        bus.launch_valid = lv; bus.launch_reg = lr; bus.launch_tag = lt;
        bus.commit_valid = cv; bus.commit_reg = cr; bus.commit_tag = ct; bus.commit_value = cval;
        bus.rd_addr = {a1, a0};
        addr[0] = a0; addr[1] = a1;
        #1;
        for (int k = 0; k < NREAD; k++) begin
            bit e_busy;
            logic [XLEN-1:0] e_val;
            e_busy = (addr[k] != 0) && m_busy[addr[k]];
            e_val  = (addr[k] != 0) ? m_val[addr[k]] : '0;
            if (rdy && cv && addr[k] != 0 && addr[k] == cr && m_busy[cr] && m_tag[cr] == ct) begin
                e_busy = 1'b0;
                e_val  = cval;
            end
            if (rdy && clr) e_busy = 1'b0;
            check($sformatf("rd_busy[%0d]", k), 64'(bus.rd_busy[k]), 64'(e_busy));
            if (e_busy)
                check($sformatf("rd_tag[%0d]", k), 64'(bus.rd_tag[k*TAG_W +: TAG_W]), 64'(m_tag[addr[k]]));
            else
                check($sformatf("rd_value[%0d]", k), 64'(bus.rd_value[k*XLEN +: XLEN]), 64'(e_val));
        end
        check("busy_cnt", 64'(bus.busy_cnt), 64'(model_cnt()));
        @(posedge clk_in);
        if (rdy) begin
            rel = 1'b0;
            if (cv && cr != 0) begin
                rel = m_busy[cr] && m_tag[cr] == ct && !(lv && lr == cr);
                m_val[cr] = cval;
            end
            if (clr) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (rel) m_busy[cr] = 1'b0;
                if (lv && lr != 0) begin
                    m_busy[lr] = 1'b1;
                    m_tag[lr]  = lt;
                end
            end
            m_prev = '{v: cv, tag: ct, val: cval};
        end
        exp_q.push_back(m_prev);
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    endtask

    task automatic launch(input logic [4:0] r, input logic [TAG_W-1:0] t, input logic [4:0] a0, input logic [4:0] a1);
        cycle(1, 0, 1, r, t, 0, 0, 0, 0, a0, a1);
    endtask

    task automatic commit(input logic [4:0] r, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                          input logic [4:0] a0, input logic [4:0] a1);
        cycle(1, 0, 0, 0, 0, 1, r, t, v, a0, a1);
    endtask

    initial begin
        bus.rdy_in = 0; bus.clear_in = 0;
        bus.launch_valid = 0; bus.launch_reg = '0; bus.launch_tag = '0;
        bus.commit_valid = 0; bus.commit_reg = '0; bus.commit_tag = '0; bus.commit_value = '0;
        bus.rd_addr = '0;
        model_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Launch/commit r5 with tag 0, bypass in the commit cycle
        launch(5, 0, 5, 0);
        idle(5, 0);
        commit(5, 0, 32'hDEAD_BEEF, 5, 5);
        idle(5, 0);

        // Older rename commits after a newer one: r7 stays busy with tag 9
        launch(7, 3, 7, 0);
        launch(7, 9, 7, 0);
        commit(7, 3, 32'h11, 7, 0);
        idle(7, 0);

        // Same-cycle launch r8 tag 4 + commit r8 tag 2: launch wins
        launch(8, 2, 8, 0);
        cycle(1, 0, 1, 8, 4, 1, 8, 2, 32'h22, 8, 7);
        idle(8, 7);

        // Flush with a concurrent commit to r2
        launch(1, 1, 1, 2);
        launch(2, 2, 2, 3);
        launch(3, 3, 3, 1);
        cycle(1, 1, 1, 4, 6, 1, 2, 2, 32'h55, 2, 3);
        idle(2, 1);
        idle(3, 4);

        // r0 is never written nor busy, but still broadcasts
        cycle(1, 0, 1, 0, 5, 1, 0, 5, 32'h99, 0, 0);
        idle(0, 0);
        // Frozen cycle: nothing changes, broadcast holds
        launch(9, 7, 9, 0);
        cycle(0, 0, 1, 10, 1, 1, 9, 7, 32'h77, 9, 10);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        idle(9, 10);

        // Mid-run async reset with registers busy
        launch(11, 1, 11, 9);
        launch(12, 2, 11, 12);
        @(negedge clk_in);
        bus.launch_valid = 0; bus.commit_valid = 0; bus.clear_in = 0; bus.rd_addr = {5'd12, 5'd11};
        #2 rst_in = 1'b1;
        #1;
        check("rst rd_busy", 64'(bus.rd_busy), 64'd0);
        check("rst rd_value", 64'(bus.rd_value), 64'd0);
        check("rst busy_cnt", 64'(bus.busy_cnt), 64'd0);
        check("rst bcast_valid", 64'(bus.bcast_valid), 64'd0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        #2 rst_in = 1'b0;

        // Random traffic concentrated on a few registers and tags to force collisions
        for (int n = 0; n < 400; n++) begin
            bit rdy, clr, lv, cv;
            logic [4:0] lr, cr, a0, a1;
            logic [TAG_W-1:0] lt, ct;
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 29) == 0);
            lv  = $urandom_range(0, 1);
            cv  = $urandom_range(0, 1);
            lr  = 5'($urandom_range(0, 7));
            cr  = 5'($urandom_range(0, 7));
            lt  = TAG_W'($urandom_range(0, 3));
            ct  = $urandom_range(0, 2) != 0 ? m_tag[cr] : TAG_W'($urandom_range(0, 31));
            a0  = ($urandom_range(0, 1) != 0) ? cr : 5'($urandom_range(0, 31));
            a1  = 5'($urandom_range(0, 8));
            cycle(rdy, clr, lv, lr, lt, cv, cr, ct, $urandom, a0, a1);
        end
        idle(1, 2);
        idle(3, 4);
        @(negedge clk_in);
        @(negedge clk_in);
        check("queue drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
